// File: rtl/trng_health_monitor.sv
// trng_health_monitor: RCT/APT continuous health tests with start-up gating and sticky alarms.
module trng_health_monitor #(
  parameter int RCT_CUTOFF = 34,
  parameter int APT_WINDOW = 512,
  parameter int APT_CUTOFF = 410
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_valid,
  input  logic bit_in,
  input  logic clear_alarm,
  output logic bit_out,
  output logic bit_out_valid,
  output logic rct_alarm,
  output logic apt_alarm,
  output logic alarm,
  output logic ready
);
  localparam int RW = $clog2(RCT_CUTOFF + 1);
  localparam int AW = $clog2(APT_WINDOW + 1);
  localparam logic [RW-1:0] RMAX = RW'(RCT_CUTOFF);
  localparam logic [AW-1:0] WMAX = AW'(APT_WINDOW);
  localparam logic [AW-1:0] AMAX = AW'(APT_CUTOFF);
  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic [AW-1:0] win_cnt_q, win_cnt_d, apt_cnt_q, apt_cnt_d;
  logic last_bit_q, ref_bit_q, ref_bit_d;
  logic new_win, rct_d, apt_d, pass, ready_d;
  // run_cnt == 0 marks the first sample since reset or clear
  always_comb begin
    run_cnt_d = (run_cnt_q == '0 || bit_in != last_bit_q) ? RW'(1) :
                (run_cnt_q == RMAX) ? RMAX : run_cnt_q + 1'b1;
    new_win   = win_cnt_q == '0 || win_cnt_q == WMAX;
    win_cnt_d = new_win ? AW'(1) : win_cnt_q + 1'b1;
    apt_cnt_d = new_win ? AW'(1) :
                (bit_in == ref_bit_q && apt_cnt_q != AMAX) ? apt_cnt_q + 1'b1 : apt_cnt_q;
    ref_bit_d = new_win ? bit_in : ref_bit_q;
    rct_d     = rct_alarm | (run_cnt_d == RMAX);
    apt_d     = apt_alarm | (apt_cnt_d == AMAX);
    pass      = ready & ~rct_d & ~apt_d;
    ready_d   = ~(rct_d | apt_d) & (ready | (win_cnt_d == WMAX));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt_q     <= '0;
      win_cnt_q     <= '0;
      apt_cnt_q     <= '0;
      last_bit_q    <= 1'b0;
      ref_bit_q     <= 1'b0;
      bit_out       <= 1'b0;
      bit_out_valid <= 1'b0;
      rct_alarm     <= 1'b0;
      apt_alarm     <= 1'b0;
      alarm         <= 1'b0;
      ready         <= 1'b0;
    end else if (clear_alarm) begin
      run_cnt_q     <= '0;
      win_cnt_q     <= '0;
      apt_cnt_q     <= '0;
      bit_out_valid <= 1'b0;
      rct_alarm     <= 1'b0;
      apt_alarm     <= 1'b0;
      alarm         <= 1'b0;
      ready         <= 1'b0;
    end else if (bit_valid) begin
      run_cnt_q     <= run_cnt_d;
      win_cnt_q     <= win_cnt_d;
      apt_cnt_q     <= apt_cnt_d;
      last_bit_q    <= bit_in;
      ref_bit_q     <= ref_bit_d;
      bit_out       <= pass ? bit_in : bit_out;
      bit_out_valid <= pass;
      rct_alarm     <= rct_d;
      apt_alarm     <= apt_d;
      alarm         <= rct_d | apt_d;
      ready         <= ready_d;
    end else begin
      bit_out_valid <= 1'b0;
    end
  end
endmodule
